// File: rtl/temporizador_microondas.sv
`default_nettype none
// ============================================================================
// Module : temporizador_microondas
// Cook timer with BCD min:sec store, power duty control, lamp and end beeper.
// Rev    : 1.0
// ============================================================================
module temporizador_microondas #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int MAX_MIN   = 99,
  parameter int POT_W     = 2,
  parameter int BEEP_SEC  = 3,
  parameter int QUICK_SEC = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mais,
  input  logic             menos,
  input  logic             potencia,
  input  logic             porta,
  input  logic             sec_mod,
  input  logic [1:0]       min_mod,
  output logic [7:0]       min_bcd,
  output logic [7:0]       sec_bcd,
  output logic [POT_W-1:0] pot_level,
  output logic             magnetron,
  output logic             lampada,
  output logic             beep,
  output logic [1:0]       estado
);

  localparam int N_POT     = 2 ** POT_W;
  localparam int PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BEEP_W    = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam int MAX_MIN_C = (MAX_MIN < 1) ? 1 : ((MAX_MIN > 99) ? 99 : MAX_MIN);

  localparam logic [7:0]         MAX_MIN_EXT = 8'(MAX_MIN_C);
  localparam logic [6:0]         MAX_MIN_V   = 7'(MAX_MIN_C);
  localparam logic [6:0]         QUICK_MIN   = 7'(QUICK_SEC / 60);
  localparam logic [5:0]         QUICK_S     = 6'(QUICK_SEC % 60);
  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST   = BEEP_W'(BEEP_SEC - 1);
  localparam logic [POT_W-1:0]   POT_MAX     = POT_W'(N_POT - 1);

  // Button vector ordered by priority, bit 0 highest
  localparam int B_STOP  = 0;
  localparam int B_PAUSE = 1;
  localparam int B_START = 2;
  localparam int B_MAIS  = 3;
  localparam int B_MENOS = 4;
  localparam int B_POT   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } estado_t;

  function automatic logic [12:0] time_add(input logic [6:0] m, input logic [5:0] s,
                                           input logic [6:0] dm, input logic [5:0] ds);
    logic [6:0] s_sum;
    logic [7:0] m_sum;
    logic       carry;
    s_sum = {1'b0, s} + {1'b0, ds};
    carry = (s_sum >= 7'd60);
    if (carry) s_sum = s_sum - 7'd60;
    m_sum = {1'b0, m} + {1'b0, dm} + {7'd0, carry};
    if (m_sum > MAX_MIN_EXT) time_add = {MAX_MIN_V, 6'd59};
    else                     time_add = {m_sum[6:0], s_sum[5:0]};
  endfunction

  // Seconds wrap modulo 64 is harmless: the true result always lands in 0..59
  function automatic logic [12:0] time_sub(input logic [6:0] m, input logic [5:0] s,
                                           input logic [6:0] dm, input logic [5:0] ds);
    logic [5:0] s_dif;
    logic [7:0] m_dif;
    logic       borrow;
    borrow = (s < ds);
    s_dif  = borrow ? (s + 6'd60 - ds) : (s - ds);
    m_dif  = {1'b0, m} - {1'b0, dm} - {7'd0, borrow};
    if (m_dif[7]) time_sub = '0;
    else          time_sub = {m_dif[6:0], s_dif};
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    to_bcd = {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  logic [5:0]         btn_lvl;
  logic [5:0]         btn_prev_q;
  logic [5:0]         btn_pulse_q, btn_pulse_d;
  logic [5:0]         act;
  logic               porta_q;
  logic               sec_mod_q;
  logic [1:0]         min_mod_q;
  estado_t            estado_q, estado_d;
  logic [12:0]        time_q, time_d, time_run;
  logic [POT_W-1:0]   pot_q, pot_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [POT_W-1:0]   w_q, w_d;
  logic [BEEP_W-1:0]  beep_cnt_q, beep_cnt_d;
  logic [7:0]         min_bcd_q, min_bcd_d;
  logic [7:0]         sec_bcd_q, sec_bcd_d;
  logic               magnetron_q, magnetron_d;
  logic               lampada_q, lampada_d;
  logic               beep_q, beep_d;
  logic [6:0]         step_m;
  logic [5:0]         step_s;
  logic               tick;
  logic               time_zero;

  assign btn_lvl     = {potencia, menos, mais, start, pause, stop};
  assign btn_pulse_d = btn_lvl & ~btn_prev_q;
  // Keep only the highest-priority pending event
  assign act         = btn_pulse_q & (~btn_pulse_q + 6'd1);
  assign tick        = (presc_q == PRESC_LAST);
  assign time_zero   = (time_q == '0);

  always_comb begin
    step_m = 7'd0;
    step_s = 6'd0;
    if (sec_mod_q) begin
      step_s = 6'd10;
    end else begin
      case (min_mod_q)
        2'b00:   step_s = 6'd1;
        2'b01:   step_m = 7'd1;
        2'b10:   step_m = 7'd5;
        default: step_m = 7'd10;
      endcase
    end
  end

  always_comb begin
    estado_d   = estado_q;
    time_d     = time_q;
    time_run   = time_q;
    pot_d      = pot_q;
    presc_d    = presc_q;
    w_d        = w_q;
    beep_cnt_d = beep_cnt_q;
    case (estado_q)
      IDLE: begin
        if (act[B_STOP]) begin
          time_d = '0;
          pot_d  = POT_MAX;
        end else if (act[B_START]) begin
          if (!porta_q) begin
            if (time_zero) time_d = time_add(7'd0, 6'd0, QUICK_MIN, QUICK_S);
            estado_d = RUN;
            presc_d  = '0;
            w_d      = '0;
          end
        end else if (act[B_MAIS]) begin
          time_d = time_add(time_q[12:6], time_q[5:0], step_m, step_s);
        end else if (act[B_MENOS]) begin
          time_d = time_sub(time_q[12:6], time_q[5:0], step_m, step_s);
        end else if (act[B_POT]) begin
          pot_d = pot_q + 1'b1;
        end
      end
      RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          time_run = time_sub(time_q[12:6], time_q[5:0], 7'd0, 6'd1);
          w_d      = w_q + 1'b1;
        end
        if (act[B_MAIS] && !porta_q)
          time_d = time_add(time_run[12:6], time_run[5:0], QUICK_MIN, QUICK_S);
        else
          time_d = time_run;
        // Reaching zero wins over a simultaneous pause so a cook never resumes at 00:00
        if (tick && time_d == '0) begin
          estado_d   = DONE;
          beep_cnt_d = '0;
        end else if (porta_q || act[B_STOP] || act[B_PAUSE]) begin
          estado_d = PAUSED;
        end
      end
      PAUSED: begin
        if (act[B_STOP]) begin
          estado_d = IDLE;
          time_d   = '0;
        end else if (act[B_START] && !porta_q) begin
          estado_d = RUN;
        end
      end
      DONE: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (porta_q || (btn_pulse_q != '0)) begin
          estado_d = IDLE;
          time_d   = '0;
        end else if (tick) begin
          if (beep_cnt_q == BEEP_LAST) begin
            estado_d = IDLE;
            time_d   = '0;
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end
      end
    endcase

    min_bcd_d   = to_bcd(time_d[12:6]);
    sec_bcd_d   = to_bcd({1'b0, time_d[5:0]});
    magnetron_d = (estado_d == RUN) && !porta_q && (w_d <= pot_d);
    lampada_d   = (estado_d == RUN) || porta_q;
    beep_d      = (estado_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      btn_prev_q  <= '0;
      btn_pulse_q <= '0;
      porta_q     <= 1'b0;
      sec_mod_q   <= 1'b0;
      min_mod_q   <= 2'b00;
      estado_q    <= IDLE;
      time_q      <= '0;
      pot_q       <= POT_MAX;
      presc_q     <= '0;
      w_q         <= '0;
      beep_cnt_q  <= '0;
      min_bcd_q   <= 8'h00;
      sec_bcd_q   <= 8'h00;
      magnetron_q <= 1'b0;
      lampada_q   <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      btn_prev_q  <= btn_lvl;
      btn_pulse_q <= btn_pulse_d;
      porta_q     <= porta;
      sec_mod_q   <= sec_mod;
      min_mod_q   <= min_mod;
      estado_q    <= estado_d;
      time_q      <= time_d;
      pot_q       <= pot_d;
      presc_q     <= presc_d;
      w_q         <= w_d;
      beep_cnt_q  <= beep_cnt_d;
      min_bcd_q   <= min_bcd_d;
      sec_bcd_q   <= sec_bcd_d;
      magnetron_q <= magnetron_d;
      lampada_q   <= lampada_d;
      beep_q      <= beep_d;
    end
  end

  assign min_bcd   = min_bcd_q;
  assign sec_bcd   = sec_bcd_q;
  assign pot_level = pot_q;
  assign magnetron = magnetron_q;
  assign lampada   = lampada_q;
  assign beep      = beep_q;
  assign estado    = estado_q;

endmodule
`default_nettype wire
